// File: rtl/axis_s2mm_pkt_source_if.sv
// AXI4-Stream bundle between the packet source and the DMA S2MM slave.
// Master drives payload/valid/last; slave drives ready.
interface axis_s2mm_pkt_source_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int KEEP_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_W-1:0]     tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_s2mm_pkt_source.sv
// Packet generator feeding the DMA S2MM stream: one packet per start,
// incrementing payload seeded per packet, optional idle gaps between beats.
module axis_s2mm_pkt_source #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 4
) (
    input  logic                  axi_aclk,
    input  logic                  axi_reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    output logic                  busy,
    output logic                  done,
    axis_s2mm_pkt_source_if.master s_axis_s2mm
);
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int KB     = $clog2(KEEP_W);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t state, state_n;

    logic [LEN_WIDTH-1:0]  beat;
    logic [LEN_WIDTH-1:0]  nxt_beat;
    logic [LEN_WIDTH-1:0]  last_idx;
    logic [LEN_WIDTH-1:0]  cap_idx;
    logic [KEEP_W-1:0]     last_keep;
    logic [KEEP_W-1:0]     cap_keep;
    logic [GAP_WIDTH-1:0]  gap_q;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic [KB-1:0]         rem;
    logic                  accept;
    logic                  hs;

    // tvalid is high exactly in SEND, so a handshake is SEND && tready
    assign hs       = (state == SEND) && s_axis_s2mm.tready;
    assign accept   = (state == IDLE) && start && (pkt_len != '0);
    assign cap_idx  = (pkt_len - LEN_WIDTH'(1)) >> KB;
    assign rem      = pkt_len[KB-1:0];
    assign nxt_beat = beat + LEN_WIDTH'(1);

    // Byte mask for the final beat: full word when length is word aligned
    always_comb begin
        cap_keep = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            cap_keep[i] = (rem == '0) || (KB'(i) < rem);
        end
    end

    // Next-state decode
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = (pkt_len != '0) ? SEND : DONE;
                end
            end
            SEND: begin
                if (hs) begin
                    if (s_axis_s2mm.tlast) begin
                        state_n = DONE;
                    end else if (gap_q != '0) begin
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_WIDTH'(1)) begin
                    state_n = SEND;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Registered outputs, beat counter and captured packet parameters
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            busy               <= 1'b0;
            done               <= 1'b0;
            s_axis_s2mm.tvalid <= 1'b0;
            s_axis_s2mm.tlast  <= 1'b0;
            s_axis_s2mm.tdata  <= '0;
            s_axis_s2mm.tkeep  <= '0;
            beat               <= '0;
            last_idx           <= '0;
            last_keep          <= '0;
            gap_q              <= '0;
            gap_cnt            <= '0;
        end else begin
            busy               <= (state_n == SEND) || (state_n == GAP);
            done               <= (state_n == DONE);
            s_axis_s2mm.tvalid <= (state_n == SEND);
            if (accept) begin
                s_axis_s2mm.tdata <= seed;
                s_axis_s2mm.tlast <= (cap_idx == '0);
                s_axis_s2mm.tkeep <= (cap_idx == '0) ? cap_keep : '1;
                beat              <= '0;
                last_idx          <= cap_idx;
                last_keep         <= cap_keep;
                gap_q             <= gap_cycles;
            end else if (hs) begin
                if (s_axis_s2mm.tlast) begin
                    s_axis_s2mm.tlast <= 1'b0;
                end else begin
                    s_axis_s2mm.tdata <= s_axis_s2mm.tdata + DATA_WIDTH'(1);
                    s_axis_s2mm.tlast <= (nxt_beat == last_idx);
                    s_axis_s2mm.tkeep <= (nxt_beat == last_idx) ? last_keep : '1;
                    beat              <= nxt_beat;
                    gap_cnt           <= gap_q;
                end
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_axis_s2mm_pkt_source.sv
// Directed bench for the S2MM packet source: cycle-exact beat checks,
// random backpressure with stability checks, reset and start-ignore cases.
module tb_axis_s2mm_pkt_source;
    logic        clk;
    logic        axi_reset;
    logic        start;
    logic [15:0] pkt_len;
    logic [31:0] seed;
    logic [3:0]  gap_cycles;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    logic        q_last[$];

    logic        stall_q = 1'b0;
    logic [31:0] snap_data;
    logic [3:0]  snap_keep;
    logic        snap_last;

    axis_s2mm_pkt_source_if #(.DATA_WIDTH(32)) bus ();

    axis_s2mm_pkt_source dut (
        .axi_aclk   (clk),
        .axi_reset  (axi_reset),
        .start      (start),
        .pkt_len    (pkt_len),
        .seed       (seed),
        .gap_cycles (gap_cycles),
        .busy       (busy),
        .done       (done),
        .s_axis_s2mm(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Record every accepted beat (partial beats during reset are dropped)
    always @(posedge clk) begin
        if (!axi_reset && bus.tvalid && bus.tready) begin
            q_data.push_back(bus.tdata);
            q_keep.push_back(bus.tkeep);
            q_last.push_back(bus.tlast);
        end
        stall_q   = !axi_reset && bus.tvalid && !bus.tready;
        snap_data = bus.tdata;
        snap_keep = bus.tkeep;
        snap_last = bus.tlast;
    end

    // Stalled beats must hold still
    always @(negedge clk) begin
        if (stall_q && !axi_reset) begin
            check("stall_valid", bus.tvalid, 1);
            check("stall_data", bus.tdata, snap_data);
            check("stall_keep", bus.tkeep, snap_keep);
            check("stall_last", bus.tlast, snap_last);
        end
    end

    task automatic pulse_start(input logic [15:0] len, input logic [31:0] sd,
                               input logic [3:0] gap);
        pkt_len    = len;
        seed       = sd;
        gap_cycles = gap;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d,
                               input logic [3:0] k, input logic l);
        check({tag, "_valid"}, bus.tvalid, 1);
        check({tag, "_data"}, bus.tdata, d);
        check({tag, "_keep"}, bus.tkeep, k);
        check({tag, "_last"}, bus.tlast, l);
        check({tag, "_busy"}, busy, 1);
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, bus.tvalid, 0);
        check({tag, "_last"}, bus.tlast, 0);
    endtask

    task automatic wait_done(input string tag, input int max_cyc,
                             input logic rnd_ready);
        int n = 0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            if (rnd_ready) bus.tready = 1'($urandom & 1);
            n++;
        end
        check({tag, "_timeout"}, done, 1);
        bus.tready = 1'b1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_keep.delete();
        q_last.delete();
    endtask

    initial begin
        axi_reset  = 1'b1;
        start      = 1'b0;
        pkt_len    = '0;
        seed       = '0;
        gap_cycles = '0;
        bus.tready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_last", bus.tlast, 0);
        check("rst_data", bus.tdata, 0);
        check("rst_keep", bus.tkeep, 0);
        axi_reset = 1'b0;
        @(negedge clk);

        // 16 bytes back to back
        pulse_start(16, 32'hA000_0000, 0);
        expect_beat("t1b0", 32'hA000_0000, 4'hF, 0);
        @(negedge clk);
        expect_beat("t1b1", 32'hA000_0001, 4'hF, 0);
        @(negedge clk);
        expect_beat("t1b2", 32'hA000_0002, 4'hF, 0);
        @(negedge clk);
        expect_beat("t1b3", 32'hA000_0003, 4'hF, 1);
        @(negedge clk);
        expect_done("t1end");
        @(negedge clk);
        check("t1_done_pulse", done, 0);

        // 7 bytes, data wraps, partial keep
        pulse_start(7, 32'hFFFF_FFFF, 0);
        expect_beat("t2b0", 32'hFFFF_FFFF, 4'hF, 0);
        @(negedge clk);
        expect_beat("t2b1", 32'h0000_0000, 4'h7, 1);
        @(negedge clk);
        expect_done("t2end");
        @(negedge clk);

        // 8 bytes with 3 idle cycles between beats
        pulse_start(8, 32'h0000_0100, 3);
        expect_beat("t3b0", 32'h0000_0100, 4'hF, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t3gap%0d_valid", i), bus.tvalid, 0);
            check($sformatf("t3gap%0d_busy", i), busy, 1);
        end
        @(negedge clk);
        expect_beat("t3b1", 32'h0000_0101, 4'hF, 1);
        @(negedge clk);
        expect_done("t3end");
        @(negedge clk);

        // 40 bytes under random backpressure
        clear_q();
        pulse_start(40, 32'h1234_0000, 0);
        bus.tready = 1'($urandom & 1);
        wait_done("t4", 400, 1'b1);
        check("t4_count", q_data.size(), 10);
        for (int k = 0; k < 10 && k < q_data.size(); k++) begin
            check($sformatf("t4_data%0d", k), q_data[k], 32'h1234_0000 + k);
            check($sformatf("t4_keep%0d", k), q_keep[k], 4'hF);
            check($sformatf("t4_last%0d", k), q_last[k], k == 9);
        end
        @(negedge clk);

        // zero-length request: only a done pulse
        pulse_start(0, 32'hDEAD_0000, 0);
        expect_done("t5z");
        @(negedge clk);
        check("t5z_done_off", done, 0);
        check("t5z_busy", busy, 0);

        // start while busy and in the done cycle is ignored
        clear_q();
        pulse_start(16, 32'h7000_0000, 2);
        @(negedge clk);
        pulse_start(32, 32'h0000_0000, 0);
        wait_done("t5", 100, 1'b0);
        pulse_start(32, 32'h0000_0000, 0);
        check("t5_ign_valid", bus.tvalid, 0);
        check("t5_ign_busy", busy, 0);
        @(negedge clk);
        check("t5_ign_valid2", bus.tvalid, 0);
        check("t5_count", q_data.size(), 4);
        for (int k = 0; k < 4 && k < q_data.size(); k++) begin
            check($sformatf("t5_data%0d", k), q_data[k], 32'h7000_0000 + k);
            check($sformatf("t5_last%0d", k), q_last[k], k == 3);
        end

        // reset in the middle of a packet
        pulse_start(32, 32'h5000_0000, 0);
        @(negedge clk);
        @(negedge clk);
        check("t6_b2_data", bus.tdata, 32'h5000_0002);
        axi_reset = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", bus.tvalid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_last", bus.tlast, 0);
        check("t6_rst_done", done, 0);
        axi_reset = 1'b0;
        @(negedge clk);
        clear_q();
        pulse_start(32, 32'h6000_0000, 0);
        wait_done("t6", 100, 1'b0);
        check("t6_count", q_data.size(), 8);
        for (int k = 0; k < 8 && k < q_data.size(); k++) begin
            check($sformatf("t6_data%0d", k), q_data[k], 32'h6000_0000 + k);
            check($sformatf("t6_keep%0d", k), q_keep[k], 4'hF);
            check($sformatf("t6_last%0d", k), q_last[k], k == 7);
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
